sync_fifo_prog: RTL and testbench

Parametrised synchronous FIFO, single clock. Successor to the fixed-configuration FIFO. Adds the following:
- arbitrary (non-power-of-two) depth
- runtime-programmable almost-full/almost-empty thresholds
- selectable standard or first-word-fall-through (FWFT) read mode
- synchronous flush
- exported occupancy count

Used as the generic buffering primitive between streaming blocks; the UVM FIFO environment is extended to check it.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_ram.sv | 24 ++
 rtl/sync_fifo_prog.sv | 119 +++++++++++
 tb/tb_sync_fifo_prog.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types, defaults and the pointer-advance helper for the FIFO family.
package fifo_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;

  typedef enum logic {
    FIFO_STD,
    FIFO_FWFT
  } fifo_mode_e;

  // Advance a ring pointer. The wrap is an explicit compare against the last
  // index so that non-power-of-two depths work.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH storage: synchronous write port, asynchronous read port.
module fifo_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with arbitrary depth, programmable almost-full/empty
// thresholds, standard or first-word-fall-through read, and synchronous flush.
//
// Handshake: a write is taken on any rising edge where wr_en is high and the
// FIFO is not full; a read is taken where rd_en is high and the FIFO is not
// empty. Rejected requests raise overflow/underflow one cycle later; accepted
// writes raise wr_ack one cycle later. flush wins over both requests.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int FWFT  = 0,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  input  logic [CW-1:0]    af_thresh,
  input  logic [CW-1:0]    ae_thresh,
  output logic [WIDTH-1:0] dout,
  output logic             rd_valid,
  output logic             wr_ack,
  output logic             overflow,
  output logic             underflow,
  output logic             full,
  output logic             empty,
  output logic             almostfull,
  output logic             almostempty,
  output logic [CW-1:0]    count
);

  localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam fifo_mode_e    MODE    = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] dout_q;
  logic             rd_valid_q;
  logic [WIDTH-1:0] rdata;
  logic             wr_acc;
  logic             rd_acc;

  // Status decoded from the registered occupancy; thresholds are used live.
  // A zero af_thresh and an ae_thresh of DEPTH or more saturate naturally.
  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == '0);
  assign almostfull  = (count_q >= af_thresh);
  assign almostempty = (count_q <= ae_thresh);
  assign count       = count_q;

  // Accept decisions only look at full/empty, so a full FIFO rejects a write
  // even when a read frees a slot on the same edge, and vice versa.
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc && !flush),
    .waddr (wr_ptr),
    .wdata (din),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Pointers, occupancy, status pulses and the standard-mode output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
      wr_ack     <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      wr_ack     <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      wr_ack     <= wr_acc;
      overflow   <= wr_en && full;
      underflow  <= rd_en && empty;
      rd_valid_q <= rd_acc;
      if (rd_acc) dout_q <= rdata;
      if (wr_acc) wr_ptr <= PW'(next_ptr(32'(wr_ptr), DEPTH));
      if (rd_acc) rd_ptr <= PW'(next_ptr(32'(rd_ptr), DEPTH));
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Read-side view: FWFT exposes the head word directly from the RAM.
  if (MODE == FIFO_FWFT) begin : g_fwft
    assign dout     = rdata;
    assign rd_valid = !empty;
  end else begin : g_std
    assign dout     = dout_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: three instances (depth 8 standard, depth 5
// standard, depth 8 FWFT) share one directed stimulus stream and are checked
// every cycle against a sequence-number model of FIFO contents.
module tb_sync_fifo_prog;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] din = '0;
  logic [3:0]  af_thresh = 4'd6;
  logic [3:0]  ae_thresh = 4'd2;

  always #5 clk = ~clk;

  // ---------------- DUT outputs ----------------
  logic [15:0] dout_a [3];
  logic        rdv_a [3];
  logic        ack_a [3];
  logic        ov_a [3];
  logic        un_a [3];
  logic        full_a [3];
  logic        empty_a [3];
  logic        af_a [3];
  logic        ae_a [3];
  logic [3:0]  cnt0;
  logic [2:0]  cnt1;
  logic [3:0]  cnt2;
  logic [3:0]  cnt_a [3];

  assign cnt_a[0] = cnt0;
  assign cnt_a[1] = {1'b0, cnt1};
  assign cnt_a[2] = cnt2;

  sync_fifo_prog #(.WIDTH(16), .DEPTH(8), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .dout(dout_a[0]), .rd_valid(rdv_a[0]),
    .wr_ack(ack_a[0]), .overflow(ov_a[0]), .underflow(un_a[0]), .full(full_a[0]),
    .empty(empty_a[0]), .almostfull(af_a[0]), .almostempty(ae_a[0]), .count(cnt0));

  sync_fifo_prog #(.WIDTH(16), .DEPTH(5), .FWFT(0)) u_wrap (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .af_thresh(af_thresh[2:0]), .ae_thresh(ae_thresh[2:0]), .dout(dout_a[1]), .rd_valid(rdv_a[1]),
    .wr_ack(ack_a[1]), .overflow(ov_a[1]), .underflow(un_a[1]), .full(full_a[1]),
    .empty(empty_a[1]), .almostfull(af_a[1]), .almostempty(ae_a[1]), .count(cnt1));

  sync_fifo_prog #(.WIDTH(16), .DEPTH(8), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .dout(dout_a[2]), .rd_valid(rdv_a[2]),
    .wr_ack(ack_a[2]), .overflow(ov_a[2]), .underflow(un_a[2]), .full(full_a[2]),
    .empty(empty_a[2]), .almostfull(af_a[2]), .almostempty(ae_a[2]), .count(cnt2));

  // ---------------- model ----------------
  // Contents are tracked as a log of every accepted write plus totals of
  // words written and read; occupancy is their difference, head is log[rd].
  localparam int DEP [3] = '{8, 5, 8};
  localparam int FW  [3] = '{0, 0, 1};

  int          wtot [3];
  int          rtot [3];
  logic [15:0] wlog [3][1024];
  logic        m_ack [3];
  logic        m_ov [3];
  logic        m_un [3];
  logic        m_rv [3];
  logic [15:0] m_dout [3];
  logic [15:0] exp_q [$];

  function automatic int occ_of(int k);
    return wtot[k] - rtot[k];
  endfunction

  function automatic int af_of(int k);
    return (k == 1) ? int'(af_thresh[2:0]) : int'(af_thresh);
  endfunction

  function automatic int ae_of(int k);
    return (k == 1) ? int'(ae_thresh[2:0]) : int'(ae_thresh);
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        wtot[k] <= 0; rtot[k] <= 0;
        m_ack[k] <= 1'b0; m_ov[k] <= 1'b0; m_un[k] <= 1'b0; m_rv[k] <= 1'b0;
        m_dout[k] <= '0;
      end else if (flush) begin
        rtot[k] <= wtot[k];
        m_ack[k] <= 1'b0; m_ov[k] <= 1'b0; m_un[k] <= 1'b0; m_rv[k] <= 1'b0;
      end else begin
        m_ack[k] <= wr_en && (occ_of(k) != DEP[k]);
        m_ov[k]  <= wr_en && (occ_of(k) == DEP[k]);
        m_un[k]  <= rd_en && (occ_of(k) == 0);
        m_rv[k]  <= rd_en && (occ_of(k) != 0);
        if (wr_en && occ_of(k) != DEP[k]) begin
          wlog[k][wtot[k]] <= din;
          wtot[k] <= wtot[k] + 1;
        end
        if (rd_en && occ_of(k) != 0) begin
          m_dout[k] <= wlog[k][rtot[k]];
          rtot[k] <= rtot[k] + 1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      int c;
      c = occ_of(k);
      chk($sformatf("u%0d_count", k), 32'(cnt_a[k]), c);
      chk($sformatf("u%0d_full", k), 32'(full_a[k]), (c == DEP[k]) ? 1 : 0);
      chk($sformatf("u%0d_empty", k), 32'(empty_a[k]), (c == 0) ? 1 : 0);
      chk($sformatf("u%0d_almostfull", k), 32'(af_a[k]), (c >= af_of(k)) ? 1 : 0);
      chk($sformatf("u%0d_almostempty", k), 32'(ae_a[k]), (c <= ae_of(k)) ? 1 : 0);
      chk($sformatf("u%0d_wr_ack", k), 32'(ack_a[k]), 32'(m_ack[k]));
      chk($sformatf("u%0d_overflow", k), 32'(ov_a[k]), 32'(m_ov[k]));
      chk($sformatf("u%0d_underflow", k), 32'(un_a[k]), 32'(m_un[k]));
      if (FW[k] != 0) begin
        chk($sformatf("u%0d_rd_valid", k), 32'(rdv_a[k]), (c != 0) ? 1 : 0);
        if (c != 0) chk($sformatf("u%0d_dout", k), 32'(dout_a[k]), 32'(wlog[k][rtot[k]]));
      end else begin
        chk($sformatf("u%0d_rd_valid", k), 32'(rdv_a[k]), 32'(m_rv[k]));
        chk($sformatf("u%0d_dout", k), 32'(dout_a[k]), 32'(m_dout[k]));
      end
    end
    // Read-order scoreboard for the depth-8 standard instance.
    if (rdv_a[0] === 1'b1) begin
      if (exp_q.size() == 0) chk("u0_unexpected_read", 32'(dout_a[0]), 32'hFFFF_FFFF);
      else chk("u0_read_order", 32'(dout_a[0]), 32'(exp_q.pop_front()));
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change on the falling edge; outputs are checked there too.
  task automatic cyc(input logic w, input logic [15:0] d, input logic r, input logic f);
    wr_en = w; din = d; rd_en = r; flush = f;
    @(posedge clk);
    if (f) exp_q.delete();
    else begin
      if (r && cnt0 != 0) ; // read pops at compare time
      if (w && cnt0 != 4'd8) exp_q.push_back(d);
    end
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    compare_all();
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 0, 0, 0);
    chk("reset_count", 32'(cnt0), 0);
    chk("reset_empty", 32'(empty_a[0]), 1);
    chk("reset_almostempty", 32'(ae_a[0]), 1);
    chk("reset_dout", 32'(dout_a[0]), 0);

    // Reset in the middle of a cycle must clear state without a clock edge.
    for (int i = 0; i < 5; i++) cyc(1, 16'h0010 + 16'(i), 0, 0);
    chk("pre_reset_count", 32'(cnt0), 5);
    chk("pre_reset_wr_ack", 32'(ack_a[0]), 1);
    #1 rst = 1'b1;
    #1;
    exp_q.delete();
    chk("async_reset_count", 32'(cnt0), 0);
    chk("async_reset_empty", 32'(empty_a[0]), 1);
    chk("async_reset_full", 32'(full_a[0]), 0);
    chk("async_reset_wr_ack", 32'(ack_a[0]), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    compare_all();
    cyc(1, 16'h1234, 0, 0);
    cyc(0, 0, 1, 0);
    chk("after_reset_read", 32'(dout_a[0]), 32'h1234);
    chk("after_reset_rd_valid", 32'(rdv_a[0]), 1);

    // Fill, thresholds (af=6, ae=2), overflow.
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 16'(i), 0, 0);
      if (i == 2) chk("ae_at_2", 32'(ae_a[0]), 1);
      if (i == 3) chk("ae_drops_at_3", 32'(ae_a[0]), 0);
      if (i == 5) chk("af_low_at_5", 32'(af_a[0]), 0);
      if (i == 6) chk("af_rises_at_6", 32'(af_a[0]), 1);
    end
    chk("fill_full", 32'(full_a[0]), 1);
    chk("fill_count", 32'(cnt0), 8);
    cyc(1, 16'h0009, 0, 0);
    chk("ovf_flag", 32'(ov_a[0]), 1);
    chk("ovf_wr_ack", 32'(ack_a[0]), 0);
    chk("ovf_count", 32'(cnt0), 8);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 0, 1, 0);
      chk("drain_data", 32'(dout_a[0]), i);
    end
    cyc(0, 0, 1, 0);
    chk("udf_flag", 32'(un_a[0]), 1);
    chk("udf_rd_valid", 32'(rdv_a[0]), 0);

    // Simultaneous write and read at count 0, 3 and DEPTH.
    cyc(1, 16'h0055, 1, 0);
    chk("simul0_count", 32'(cnt0), 1);
    chk("simul0_underflow", 32'(un_a[0]), 1);
    cyc(1, 16'h0056, 0, 0);
    cyc(1, 16'h0057, 0, 0);
    cyc(1, 16'h0058, 1, 0);
    chk("simul3_count", 32'(cnt0), 3);
    chk("simul3_wr_ack", 32'(ack_a[0]), 1);
    chk("simul3_dout", 32'(dout_a[0]), 32'h55);
    for (int i = 0; i < 5; i++) cyc(1, 16'h0059 + 16'(i), 0, 0);
    chk("simul8_pre_count", 32'(cnt0), 8);
    cyc(1, 16'h00EE, 1, 0);
    chk("simul8_count", 32'(cnt0), 7);
    chk("simul8_overflow", 32'(ov_a[0]), 1);
    chk("simul8_dout", 32'(dout_a[0]), 32'h56);

    // Flush, then af_thresh = 0 with the FIFO empty.
    cyc(0, 0, 0, 1);
    chk("flush_count", 32'(cnt0), 0);
    af_thresh = 4'd0;
    #1;
    chk("af_zero_forced", 32'(af_a[0]), 1);
    compare_all();
    af_thresh = 4'd6;
    ae_thresh = 4'd8;
    cyc(1, 16'h0101, 0, 0);
    chk("ae_forced_high", 32'(ae_a[0]), 1);
    ae_thresh = 4'd2;
    cyc(0, 0, 0, 1);

    // Pointer wrap on the depth-5 instance.
    for (int i = 0; i < 12; i++) begin
      cyc(1, 16'h00A0 + 16'(i), 0, 0);
      chk("wrap_count_max1", 32'(cnt1), 1);
      cyc(0, 0, 1, 0);
      chk("wrap_data", 32'(dout_a[1]), 32'h00A0 + i);
      chk("wrap_count_zero", 32'(cnt1), 0);
    end

    // FWFT behaviour.
    cyc(1, 16'hA5A5, 0, 0);
    chk("fwft_dout", 32'(dout_a[2]), 32'hA5A5);
    chk("fwft_rd_valid", 32'(rdv_a[2]), 1);
    cyc(1, 16'h0077, 0, 1);
    chk("fwft_flush_count", 32'(cnt2), 0);
    chk("fwft_flush_empty", 32'(empty_a[2]), 1);
    chk("fwft_flush_rd_valid", 32'(rdv_a[2]), 0);
    chk("fwft_flush_wr_ack", 32'(ack_a[2]), 0);
    cyc(1, 16'h00B1, 0, 0);
    cyc(1, 16'h00B2, 0, 0);
    chk("fwft_head", 32'(dout_a[2]), 32'hB1);
    cyc(0, 0, 1, 0);
    chk("fwft_next", 32'(dout_a[2]), 32'hB2);
    cyc(0, 0, 1, 0);
    chk("fwft_drained", 32'(rdv_a[2]), 0);
    repeat (3) cyc(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
